btn_pulse_gen: RTL and testbench

Conditions a raw push-button from the lab board into a clean single-cycle step pulse. The pulse drives the x_in input of the downstream 2-bit Moore step counter. The block contains a 2-flop synchronizer, a debounce counter and a 4-state Moore FSM. It emits exactly one pulse per debounced press, plus optional auto-repeat while the button is held.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/btn_pulse_gen.sv | 132 +++++++++++++
 tb/tb_btn_pulse_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and default timing constants.
// The downstream step counter is expected to import this package as well.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_DELAY_DEF    = 8;
  localparam int REPEAT_PERIOD_DEF   = 4;
  localparam int CNT_W_DEF           = 16;

  // The debounced level is asserted whenever the FSM considers the button down.
  function automatic logic is_pressed(btn_state_t s);
    return (s == HELD) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce counter and Moore FSM producing one step pulse per press.
// Define BTN_AUTOREPEAT_EN to add periodic repeat pulses while the button stays held.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       x_pulse,
  output logic       btn_level,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;
  logic             rpt_fire;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (btn_sync)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // rpt_armed marks that the initial delay has elapsed and the shorter period now applies.
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_armed, rpt_armed_nxt;

  always_comb begin
    rpt_fire      = 1'b0;
    rpt_cnt_nxt   = '0;
    rpt_armed_nxt = 1'b0;
    // Only a cycle that stays in HELD advances the repeat timer; any other path clears it.
    if (state == HELD && btn_sync) begin
      rpt_armed_nxt = rpt_armed;
      if (rpt_cnt == (rpt_armed ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire      = 1'b1;
        rpt_cnt_nxt   = '0;
        rpt_armed_nxt = 1'b1;
      end else begin
        rpt_cnt_nxt = rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else begin
          pulse_nxt = rpt_fire;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      x_pulse   <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      x_pulse   <= pulse_nxt;
      btn_level <= is_pressed(state_nxt);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: stimulus queues expected pulse cycles, a forked monitor matches each x_pulse.
// Repeat-pulse expectations are added when BTN_AUTOREPEAT_EN is defined.
module tb_btn_pulse_gen;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       x_pulse;
  logic       btn_level;
  logic [1:0] fsm_state;

  btn_pulse_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .x_pulse  (x_pulse),
    .btn_level(btn_level),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 2-bit step counter fed by x_pulse.
  logic [1:0] step_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_cnt <= 2'd0;
    else if (x_pulse) step_cnt <= step_cnt + 2'd1;
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic prev_x = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (x_pulse === 1'b1) begin
        check("pulse_gap", 32'(prev_x), 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("pulse_time", cyc, exp_q.pop_front());
        end
      end
      prev_x = x_pulse;
    end
  endtask

  task automatic at(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Queue repeat pulses for a HELD stretch entered at edge e and left at edge r.
  task automatic push_repeats(int e, int r);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = e + REPEAT_DELAY_DEF; t < r; t += REPEAT_PERIOD_DEF) exp_q.push_back(t);
`else
    if (r < e) $display("note: empty hold window %0d..%0d", e, r);
`endif
  endtask

  task automatic check_io(string name, logic [1:0] st, logic lvl);
    check({name, "_state"}, 32'(fsm_state), 32'(st));
    check({name, "_level"}, 32'(btn_level), 32'(lvl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c2;
    int e;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", 32'(x_pulse), 32'd0);
    check_io("rst", 2'b00, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: clean press, 20 cycles high
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    push_repeats(c + 7, c + 23);
    at(c + 2);  check_io("t1_sync", 2'b00, 1'b0);
    at(c + 3);  check_io("t1_pw", 2'b01, 1'b0);
    at(c + 6);  check_io("t1_pw_last", 2'b01, 1'b0);
    at(c + 7);  check_io("t1_held", 2'b10, 1'b1);
    at(c + 20); btn_raw = 1'b0;
    at(c + 23); check_io("t1_rw", 2'b11, 1'b1);
    at(c + 26); check_io("t1_rw_last", 2'b11, 1'b1);
    at(c + 27); check_io("t1_idle", 2'b00, 1'b0);
    at(c + 30); check("t1_pending", exp_q.size(), 0);

    // 2: press bounce, no pulse
    c = cyc;
    btn_raw = 1'b1;
    at(c + 2);  btn_raw = 1'b0;
    at(c + 3);  btn_raw = 1'b1;
    at(c + 4);  check_io("t2_pw", 2'b01, 1'b0);
    at(c + 5);  btn_raw = 1'b0; check_io("t2_reject", 2'b00, 1'b0);
    at(c + 7);  check_io("t2_pw2", 2'b01, 1'b0);
    at(c + 12); check_io("t2_idle", 2'b00, 1'b0);
    check("t2_pending", exp_q.size(), 0);

    // 3: release bounce after a stable press
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    push_repeats(c + 7, c + 15);
    at(c + 12); btn_raw = 1'b0;
    at(c + 14); btn_raw = 1'b1;
    at(c + 15); btn_raw = 1'b0; check_io("t3_rw", 2'b11, 1'b1);
    at(c + 17); check_io("t3_back_held", 2'b10, 1'b1);
    at(c + 18); check_io("t3_rw2", 2'b11, 1'b1);
    at(c + 21); check_io("t3_rw2_last", 2'b11, 1'b1);
    at(c + 22); check_io("t3_idle", 2'b00, 1'b0);
    at(c + 26); check("t3_pending", exp_q.size(), 0);

    // 4: reset while PRESS_WAIT holds cnt=2, button kept high
    c = cyc;
    btn_raw = 1'b1;
    at(c + 5);  check_io("t4_pw", 2'b01, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_pulse", 32'(x_pulse), 32'd0);
    check_io("t4_rst", 2'b00, 1'b0);
    at(c + 7);
    rst_n = 1'b1;
    c2 = cyc;
    exp_q.push_back(c2 + 7);
    push_repeats(c2 + 7, c2 + 23);
    at(c2 + 6);  check_io("t4_pw_after", 2'b01, 1'b0);
    at(c2 + 7);  check_io("t4_held", 2'b10, 1'b1);
    at(c2 + 20); btn_raw = 1'b0;
    at(c2 + 30); check_io("t4_idle", 2'b00, 1'b0);
    check("t4_pending", exp_q.size(), 0);

    // 5: five presses into the step counter, expect 1,2,3,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_step_init", 32'(step_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      btn_raw = 1'b1;
      exp_q.push_back(c + 7);
      push_repeats(c + 7, c + 13);
      at(c + 10); btn_raw = 1'b0;
      at(c + 20); check($sformatf("t5_step%0d", i), 32'(step_cnt), 32'((i + 1) % 4));
    end
    check("t5_pending", exp_q.size(), 0);

    // 6: 30 cycles in HELD; repeats only with auto-repeat build
    c = cyc;
    e = c + 7;
    btn_raw = 1'b1;
    exp_q.push_back(e);
    push_repeats(e, e + 30);
    at(e + 27); btn_raw = 1'b0;
    at(e + 29); check_io("t6_held_end", 2'b10, 1'b1);
    at(e + 30); check_io("t6_rw", 2'b11, 1'b1);
    at(e + 40); check_io("t6_idle", 2'b00, 1'b0);

    repeat (5) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
